conv_nm: RTL and testbench

CONV_NM -- requirements
Module: conv_nm

---
 rtl/conv_pkg.sv | 11 +
 rtl/conv_nm_mem.sv | 21 ++
 rtl/conv_nm.sv | 149 ++++++++++++++
 tb/tb_conv_nm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv_nm sliding-window convolver.
package conv_pkg;

  typedef enum logic [1:0] {LOAD, MAC, HOLD} conv_state_t;

  // Output width that holds any sum of m products of xw x fw signed words.
  function automatic int conv_yw(input int xw, input int fw, input int m);
    return xw + fw + $clog2(m);
  endfunction

endpackage

// File: rtl/conv_nm_mem.sv
// Single-port word memory: registered read (one cycle), read-before-write on the same address.
module conv_nm_mem #(
  parameter  int W  = 8,
  parameter  int D  = 8,
  localparam int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [D];

  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_addr];
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/conv_nm.sv
// Loads N x samples and M taps, then emits y[k] = sum x[k+j]*f[j] for k = 0..N-M, one per handshake.
// Optional CONV_NM_RELU_EN clamps negative results to zero without changing latency.
module conv_nm
  import conv_pkg::*;
#(
  parameter  int XW = 8,
  parameter  int FW = 8,
  parameter  int N  = 8,
  parameter  int M  = 4,
  localparam int YW = conv_yw(XW, FW, M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] s_data_in_x,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  input  logic [FW-1:0] s_data_in_f,
  input  logic          s_valid_f,
  output logic          s_ready_f,
  output logic [YW-1:0] m_data_out_y,
  output logic          m_valid_y,
  input  logic          m_ready_y
);

  localparam int CW  = $clog2(N + 1);
  localparam int FCW = $clog2(M + 1);
  localparam int AXW = (N > 1) ? $clog2(N) : 1;
  localparam int AFW = (M > 1) ? $clog2(M) : 1;

  conv_state_t r_state, w_state_nxt;

  logic [CW-1:0]         r_cnt_x;
  logic [FCW-1:0]        r_cnt_f;
  logic [FCW-1:0]        r_mc;
  logic [AXW-1:0]        r_k;
  logic signed [YW-1:0]  r_acc;
  logic signed [YW-1:0]  r_y;

  logic                  w_x_fire, w_f_fire, w_y_fire, w_last_k;
  logic [FCW-1:0]        w_mc_rd;
  logic [AXW-1:0]        w_x_addr;
  logic [AFW-1:0]        w_f_addr;
  logic [XW-1:0]         w_x_rd;
  logic [FW-1:0]         w_f_rd;
  logic signed [XW+FW-1:0] w_prod;
  logic signed [YW-1:0]  w_prod_ext;
  logic signed [YW-1:0]  w_sum;
  logic signed [YW-1:0]  w_y_fin;

  // Handshake outputs are gated by reset so nothing transfers in the reset cycle.
  assign s_ready_x    = !reset && (r_state == LOAD) && (r_cnt_x != CW'(N));
  assign s_ready_f    = !reset && (r_state == LOAD) && (r_cnt_f != FCW'(M));
  assign m_valid_y    = !reset && (r_state == HOLD);
  assign m_data_out_y = r_y;

  assign w_x_fire = s_valid_x && s_ready_x;
  assign w_f_fire = s_valid_f && s_ready_f;
  assign w_y_fire = m_valid_y && m_ready_y;
  assign w_last_k = (r_k == AXW'(N - M));

  // MAC step c reads tap c; the final step only drains the last read.
  assign w_mc_rd  = (r_mc < FCW'(M)) ? r_mc : '0;
  assign w_x_addr = (r_state == LOAD) ? AXW'(r_cnt_x) : r_k + AXW'(w_mc_rd);
  assign w_f_addr = (r_state == LOAD) ? AFW'(r_cnt_f) : AFW'(w_mc_rd);

  conv_nm_mem #(.W(XW), .D(N)) u_xmem (
    .clk     (clk),
    .i_we    (w_x_fire),
    .i_addr  (w_x_addr),
    .i_wdata (s_data_in_x),
    .o_rdata (w_x_rd)
  );

  conv_nm_mem #(.W(FW), .D(M)) u_fmem (
    .clk     (clk),
    .i_we    (w_f_fire),
    .i_addr  (w_f_addr),
    .i_wdata (s_data_in_f),
    .o_rdata (w_f_rd)
  );

  assign w_prod     = $signed(w_x_rd) * $signed(w_f_rd);
  assign w_prod_ext = YW'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;

  always_comb begin
    w_y_fin = w_sum;
`ifdef CONV_NM_RELU_EN
    if (w_sum[YW-1]) w_y_fin = '0;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD: begin
        if (((r_cnt_x + CW'(w_x_fire)) == CW'(N)) && ((r_cnt_f + FCW'(w_f_fire)) == FCW'(M)))
          w_state_nxt = MAC;
      end
      MAC: begin
        if (r_mc == FCW'(M)) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (w_y_fire) w_state_nxt = w_last_k ? LOAD : MAC;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
      r_cnt_x <= '0;
      r_cnt_f <= '0;
      r_mc    <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        LOAD: begin
          if (w_x_fire) r_cnt_x <= r_cnt_x + CW'(1);
          if (w_f_fire) r_cnt_f <= r_cnt_f + FCW'(1);
        end
        MAC: begin
          r_mc <= r_mc + FCW'(1);
          if (r_mc != '0) r_acc <= w_sum;
          if (r_mc == FCW'(M)) r_y <= w_y_fin;
        end
        HOLD: begin
          if (w_y_fire) begin
            r_mc  <= '0;
            r_acc <= '0;
            if (w_last_k) begin
              r_k     <= '0;
              r_cnt_x <= '0;
              r_cnt_f <= '0;
            end else begin
              r_k <= r_k + AXW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_nm.sv
// Scoreboard bench for conv_nm: expected y values queued at load time, checked at each y handshake.
module tb_conv_nm;
  import conv_pkg::*;

  localparam int XW = 8;
  localparam int FW = 8;
  localparam int N  = 8;
  localparam int M  = 4;
  localparam int YW = conv_yw(XW, FW, M);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [XW-1:0] s_data_in_x = '0;
  logic          s_valid_x = 1'b0;
  logic          s_ready_x;
  logic [FW-1:0] s_data_in_f = '0;
  logic          s_valid_f = 1'b0;
  logic          s_ready_f;
  logic [YW-1:0] m_data_out_y;
  logic          m_valid_y;
  logic          m_ready_y = 1'b0;

  conv_nm #(.XW(XW), .FW(FW), .N(N), .M(M)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_x  (s_data_in_x),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .s_data_in_f  (s_data_in_f),
    .s_valid_f    (s_valid_f),
    .s_ready_f    (s_ready_f),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;
  int exp_q[$];
  int xs[N];
  int fs[M];
  int last_in = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int y_now();
    return int'($signed(m_data_out_y));
  endfunction

  task automatic push_expected();
    for (int k = 0; k <= N - M; k++) begin
      int s;
      s = 0;
      for (int j = 0; j < M; j++) s += xs[k+j] * fs[j];
`ifdef CONV_NM_RELU_EN
      if (s < 0) s = 0;
`endif
      exp_q.push_back(s);
    end
  endtask

  // Called at a negedge; inputs change at negedges, handshakes resolve at the following posedge.
  task automatic load(input bit f_first, input bit toggle);
    int xi, fi, guard;
    bit tog;
    xi = 0; fi = 0; guard = 0; tog = 1'b1;
    push_expected();
    while ((xi < N || fi < M) && guard < 200) begin
      s_valid_f   = f_first ? (fi < M) : 1'b1;
      s_data_in_f = FW'((fi < M) ? fs[fi] : 77);
      s_valid_x   = (xi < N) && (!f_first || fi == M) && (!toggle || tog);
      s_data_in_x = XW'(s_valid_x ? xs[(xi < N) ? xi : 0] : 99);
      #1;
      if (fi == M && s_valid_f) chk("rdy_f_full", int'(s_ready_f), 0);
      if (s_valid_x && s_ready_x) begin xi++; last_in = cyc; end
      if (s_valid_f && s_ready_f && fi < M) begin fi++; last_in = cyc; end
      tog = !tog;
      guard++;
      @(negedge clk);
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    #1;
    chk("load_done", int'(xi == N && fi == M), 1);
    chk("rdy_x_mac", int'(s_ready_x), 0);
    chk("rdy_f_mac", int'(s_ready_f), 0);
    @(negedge clk);
  endtask

  task automatic collect(input int hold, input bit tied, input int n_out);
    int refc, w, d0, exp_v;
    refc = last_in;
    m_ready_y = tied;
    for (int k = 0; k < n_out; k++) begin
      w = 0;
      while (!m_valid_y && w < 50) begin @(negedge clk); w++; end
      if (!m_valid_y) begin
        chk("y_timeout", 0, 1);
        m_ready_y = 1'b0;
        return;
      end
      chk("lat", cyc - refc, M + 2);
      d0 = y_now();
      if (!tied) begin
        for (int h = 1; h < hold; h++) begin
          @(negedge clk);
          chk("hold_vld", int'(m_valid_y), 1);
          chk("hold_dat", y_now(), d0);
        end
        m_ready_y = 1'b1;
      end
      if (exp_q.size() == 0) begin
        chk("q_empty", 1, 0);
        exp_v = 0;
      end else begin
        exp_v = exp_q.pop_front();
      end
      chk("y", y_now(), exp_v);
      refc = cyc;
      @(negedge clk);
      if (!tied) m_ready_y = 1'b0;
      chk("vld_drop", int'(m_valid_y), 0);
    end
    m_ready_y = 1'b0;
    if (n_out == N - M + 1) begin
      chk("rdy_x_reload", int'(s_ready_x), 1);
      chk("rdy_f_reload", int'(s_ready_f), 1);
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) xs[i] = i + 1;
    for (int j = 0; j < M; j++) fs[j] = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy_x", int'(s_ready_x), 0);
    chk("rst_rdy_f", int'(s_ready_f), 0);
    chk("rst_vld", int'(m_valid_y), 0);
    chk("rst_dat", y_now(), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy_x", int'(s_ready_x), 1);
    chk("post_rst_rdy_f", int'(s_ready_f), 1);

    // ramp, ready tied high
    set_ramp();
    load(1'b0, 1'b0);
    collect(0, 1'b1, N - M + 1);

    // ramp, ready held low 3 cycles per output
    set_ramp();
    load(1'b0, 1'b0);
    collect(3, 1'b0, N - M + 1);

    // most negative sums
    for (int i = 0; i < N; i++) xs[i] = -128;
    for (int j = 0; j < M; j++) fs[j] = 127;
    load(1'b0, 1'b0);
    collect(0, 1'b1, N - M + 1);

    // most positive sums
    for (int j = 0; j < M; j++) fs[j] = -128;
    load(1'b0, 1'b0);
    collect(2, 1'b0, N - M + 1);

    // taps first, then x with a gappy valid
    xs = '{3, -5, 7, -2, 100, -90, 1, 0};
    fs = '{2, -1, 0, 3};
    load(1'b1, 1'b1);
    collect(1, 1'b0, N - M + 1);

    // abort while output 2 is pending
    set_ramp();
    load(1'b0, 1'b0);
    collect(0, 1'b1, 2);
    w = 0;
    while (!m_valid_y && w < 50) begin @(negedge clk); w++; end
    chk("hold2_vld", int'(m_valid_y), 1);
    reset = 1'b1;
    #1;
    chk("abort_vld_now", int'(m_valid_y), 0);
    chk("abort_rdy_x_now", int'(s_ready_x), 0);
    @(negedge clk);
    chk("abort_vld_next", int'(m_valid_y), 0);
    chk("abort_dat", y_now(), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rdy_x", int'(s_ready_x), 1);
    chk("abort_rdy_f", int'(s_ready_f), 1);
    exp_q.delete();

    set_ramp();
    load(1'b0, 1'b0);
    collect(0, 1'b1, N - M + 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
